// File: rtl/uart_rx_top.sv
// UART receiver: 16x oversampled, configurable data/parity/stop/baud,
// one-cycle valid pulse with parity and framing error flags.
module uart_rx_top #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned OVS    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic [1:0] para,
    input  logic       s_num,
    input  logic       d_num,
    input  logic [1:0] bd_rate,
    output logic [7:0] out_data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned Div1200 = CLK_HZ / (1200 * OVS);
    localparam int unsigned Div2400 = CLK_HZ / (2400 * OVS);
    localparam int unsigned Div4800 = CLK_HZ / (4800 * OVS);
    localparam int unsigned Div9600 = CLK_HZ / (9600 * OVS);
    localparam int unsigned CntW    = $clog2(Div1200 + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic              rx_s1_q, rxs_q;
    logic [CntW-1:0]   div_cnt_q, div_cnt_d, div_last;
    logic [3:0]        os_q, os_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop2_q, stop2_d;
    logic              line_ok_q, line_ok_d;
    logic [7:0]        data_q, data_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic [1:0]        cfg_para_q, cfg_para_d;
    logic              cfg_s_q, cfg_s_d;
    logic              cfg_d_q, cfg_d_d;
    logic [1:0]        cfg_bd_q, cfg_bd_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              valid_q, valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              tick;
    logic              par_calc;
    int unsigned       div_sel;

    // Tick period selected by the baud rate latched at start detection.
    always_comb begin
        div_sel = Div1200;
        case (cfg_bd_q)
            2'b00:   div_sel = Div1200;
            2'b01:   div_sel = Div2400;
            2'b10:   div_sel = Div4800;
            default: div_sel = Div9600;
        endcase
        div_last = CntW'(div_sel - 1);
    end

    assign tick     = (state_q != StIdle) && (div_cnt_q == div_last);
    assign par_calc = (^data_q) ^ rxs_q;

    // Next-state logic for the receive FSM, tick counter and output registers.
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = (state_q == StIdle || tick) ? '0 : div_cnt_q + 1'b1;
        os_d         = os_q;
        bit_d        = bit_q;
        stop2_d      = stop2_q;
        line_ok_d    = line_ok_q;
        data_d       = data_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        cfg_para_d   = cfg_para_q;
        cfg_s_d      = cfg_s_q;
        cfg_d_d      = cfg_d_q;
        cfg_bd_d     = cfg_bd_q;
        out_data_d   = out_data_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            StIdle: begin
                if (rxs_q) begin
                    line_ok_d = 1'b1;
                end else if (line_ok_q) begin
                    state_d    = StStart;
                    os_d       = '0;
                    data_d     = '0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop2_d    = 1'b0;
                    cfg_para_d = para;
                    cfg_s_d    = s_num;
                    cfg_d_d    = d_num;
                    cfg_bd_d   = bd_rate;
                end
            end
            StStart: begin
                if (tick) begin
                    if (os_q == 4'd7) begin
                        // A high line at mid start bit is treated as a glitch.
                        state_d = rxs_q ? StIdle : StData;
                        os_d    = '0;
                        bit_d   = '0;
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        data_d[bit_q] = rxs_q;
                        if (bit_q == (cfg_d_q ? 3'd7 : 3'd6)) begin
                            state_d = (^cfg_para_q) ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        // Even mode wants an even count of ones, odd mode an odd count.
                        perr_d  = (cfg_para_q == 2'b10) ? par_calc : ~par_calc;
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    os_d = os_q + 4'd1;
                    if (os_q == 4'd15) begin
                        if (cfg_s_q && !stop2_q) begin
                            stop2_d = 1'b1;
                            ferr_d  = ferr_q | ~rxs_q;
                        end else begin
                            // Leaving at mid stop bit lets the next start bit follow directly.
                            state_d      = StIdle;
                            valid_d      = 1'b1;
                            out_data_d   = data_q;
                            parity_err_d = perr_q;
                            frame_err_d  = ferr_q | ~rxs_q;
                            if (ferr_q | ~rxs_q) line_ok_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rx_s1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            div_cnt_q    <= '0;
            os_q         <= '0;
            bit_q        <= '0;
            stop2_q      <= 1'b0;
            line_ok_q    <= 1'b1;
            data_q       <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            cfg_para_q   <= '0;
            cfg_s_q      <= 1'b0;
            cfg_d_q      <= 1'b1;
            cfg_bd_q     <= '0;
            out_data_q   <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_s1_q      <= rx_in;
            rxs_q        <= rx_s1_q;
            div_cnt_q    <= div_cnt_d;
            os_q         <= os_d;
            bit_q        <= bit_d;
            stop2_q      <= stop2_d;
            line_ok_q    <= line_ok_d;
            data_q       <= data_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            cfg_para_q   <= cfg_para_d;
            cfg_s_q      <= cfg_s_d;
            cfg_d_q      <= cfg_d_d;
            cfg_bd_q     <= cfg_bd_d;
            out_data_q   <= out_data_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign out_data   = out_data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top at CLK_HZ = 1_228_800 (DIV 64 @1200, 8 @9600).
module tb_uart_rx_top;

    localparam int Bt9600 = 128;
    localparam int Bt1200 = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [1:0] para;
    logic       s_num;
    logic       d_num;
    logic [1:0] bd_rate;
    logic [7:0] out_data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int v0;
    int start_cyc;
    int valid_cyc;
    logic [7:0] hist_data [0:15];
    logic       hist_perr [0:15];
    logic       hist_ferr [0:15];
    logic       hist_busy [0:15];

    uart_rx_top #(.CLK_HZ(1_228_800)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .para       (para),
        .s_num      (s_num),
        .d_num      (d_num),
        .bd_rate    (bd_rate),
        .out_data   (out_data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid pulse, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            hist_data[vcnt[3:0]] = out_data;
            hist_perr[vcnt[3:0]] = parity_err;
            hist_ferr[vcnt[3:0]] = frame_err;
            hist_busy[vcnt[3:0]] = busy;
            valid_cyc = cyc;
            vcnt = vcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int bt);
        rx_in = b;
        repeat (bt) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nd, input bit has_par,
                              input logic pbit, input int nstop, input logic stopv,
                              input int bt);
        send_bit(1'b0, bt);
        for (int i = 0; i < nd; i++) send_bit(data[i], bt);
        if (has_par) send_bit(pbit, bt);
        for (int i = 0; i < nstop; i++) send_bit(stopv, bt);
    endtask

    initial begin
        rst = 1'b1; rx_in = 1'b1; para = 2'b00; s_num = 1'b0; d_num = 1'b1; bd_rate = 2'b11;
        repeat (4) @(negedge clk);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1: 8N1 0xA5 at 9600
        v0 = vcnt;
        start_cyc = cyc;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1, Bt9600);
        repeat (Bt9600) @(negedge clk);
        check("t1_count", vcnt - v0, 1);
        check("t1_data", {24'd0, hist_data[v0[3:0]]}, 32'hA5);
        check("t1_perr", {31'd0, hist_perr[v0[3:0]]}, 32'd0);
        check("t1_ferr", {31'd0, hist_ferr[v0[3:0]]}, 32'd0);
        check("t1_busy_at_valid", {31'd0, hist_busy[v0[3:0]]}, 32'd0);
        check("t1_latency_ok", {31'd0, (valid_cyc - start_cyc) <= 1221}, 32'd1);

        // 2: 7E2 0x41, wrong then correct parity bit
        para = 2'b10; s_num = 1'b1; d_num = 1'b0;
        v0 = vcnt;
        send_frame(8'h41, 7, 1'b1, 1'b1, 2, 1'b1, Bt9600);
        repeat (Bt9600) @(negedge clk);
        check("t2a_count", vcnt - v0, 1);
        check("t2a_data", {24'd0, hist_data[v0[3:0]]}, 32'h41);
        check("t2a_perr", {31'd0, hist_perr[v0[3:0]]}, 32'd1);
        check("t2a_ferr", {31'd0, hist_ferr[v0[3:0]]}, 32'd0);
        send_frame(8'h41, 7, 1'b1, 1'b0, 2, 1'b1, Bt9600);
        repeat (Bt9600) @(negedge clk);
        check("t2b_count", vcnt - v0, 2);
        check("t2b_data", {24'd0, hist_data[v0[3:0] + 4'd1]}, 32'h41);
        check("t2b_perr", {31'd0, hist_perr[v0[3:0] + 4'd1]}, 32'd0);

        // 3: 40-clk glitch low
        para = 2'b00; s_num = 1'b0; d_num = 1'b1;
        v0 = vcnt;
        rx_in = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_busy_high", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        rx_in = 1'b1;
        repeat (100) @(negedge clk);
        check("t3_busy_low", {31'd0, busy}, 32'd0);
        check("t3_no_valid", vcnt - v0, 0);
        check("t3_data_held", {24'd0, out_data}, 32'h41);
        check("t3_perr_held", {31'd0, parity_err}, 32'd0);

        // 4: framing error then held break, then recovery
        v0 = vcnt;
        send_frame(8'h00, 8, 1'b0, 1'b0, 1, 1'b0, Bt9600);
        repeat (4000) @(negedge clk);
        check("t4_one_valid", vcnt - v0, 1);
        check("t4_data", {24'd0, hist_data[v0[3:0]]}, 32'h00);
        check("t4_ferr", {31'd0, hist_ferr[v0[3:0]]}, 32'd1);
        check("t4_idle_in_break", {31'd0, busy}, 32'd0);
        send_bit(1'b1, 2 * Bt9600);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, Bt9600);
        repeat (Bt9600) @(negedge clk);
        check("t4_recover_count", vcnt - v0, 2);
        check("t4_recover_data", {24'd0, hist_data[v0[3:0] + 4'd1]}, 32'h55);
        check("t4_recover_ferr", {31'd0, hist_ferr[v0[3:0] + 4'd1]}, 32'd0);

        // 5: reset during data bit 3 of 0x3C
        v0 = vcnt;
        send_bit(1'b0, Bt9600);
        for (int i = 0; i < 3; i++) send_bit(1'(8'h3C >> i), Bt9600);
        send_bit(1'b1, Bt9600 / 2);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3 * Bt9600) @(negedge clk);
        check("t5_no_valid", vcnt - v0, 0);
        check("t5_data_cleared", {24'd0, out_data}, 32'h00);
        check("t5_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, Bt9600);
        repeat (Bt9600) @(negedge clk);
        check("t5_count", vcnt - v0, 1);
        check("t5_data", {24'd0, out_data}, 32'h3C);

        // 6: 1200 8O1 back-to-back 0x00, 0xFF; baud input changed mid-frame
        para = 2'b01; bd_rate = 2'b00;
        v0 = vcnt;
        send_bit(1'b0, Bt1200);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) bd_rate = 2'b11;
            send_bit(1'b0, Bt1200);
        end
        send_bit(1'b1, Bt1200);
        send_bit(1'b1, Bt1200);
        bd_rate = 2'b00;
        send_frame(8'hFF, 8, 1'b1, 1'b1, 1, 1'b1, Bt1200);
        repeat (Bt1200) @(negedge clk);
        check("t6_count", vcnt - v0, 2);
        check("t6_data0", {24'd0, hist_data[v0[3:0]]}, 32'h00);
        check("t6_data1", {24'd0, hist_data[v0[3:0] + 4'd1]}, 32'hFF);
        check("t6_err0", {30'd0, hist_perr[v0[3:0]], hist_ferr[v0[3:0]]}, 32'd0);
        check("t6_err1", {30'd0, hist_perr[v0[3:0] + 4'd1], hist_ferr[v0[3:0] + 4'd1]}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
